mul_div_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 23 ++
 rtl/booth_step.sv | 30 +++
 rtl/mul_div_unit.sv | 185 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multiply/divide engine: operand width, op encoding,
// FSM states and a two's-complement magnitude helper.
package cpu_pkg;

    localparam int WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    // 0x80000000 maps to itself, which reads correctly as the unsigned magnitude 2^31.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand into
// the upper half, then a one-bit arithmetic right shift of {acc, q-1}.
module booth_step
    import cpu_pkg::*;
(
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic               qm1_i,
    input  logic [WIDTH-1:0]   a_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               qm1_o
);

    logic [WIDTH:0] hi_ext_s;
    logic [WIDTH:0] a_ext_s;
    logic [WIDTH:0] sum_s;

    // A guard bit keeps the add/subtract exact when the multiplicand is 0x80000000.
    always_comb begin
        hi_ext_s = {acc_i[2*WIDTH-1], acc_i[2*WIDTH-1:WIDTH]};
        a_ext_s  = {a_i[WIDTH-1], a_i};
        case ({acc_i[0], qm1_i})
            2'b01:   sum_s = hi_ext_s + a_ext_s;
            2'b10:   sum_s = hi_ext_s - a_ext_s;
            default: sum_s = hi_ext_s;
        endcase
        acc_o = {sum_s, acc_i[WIDTH-1:1]};
        qm1_o = acc_i[0];
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed 32x32 Booth multiplier / restoring divider with start/busy/done.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV requests report divz.
module mul_div_unit
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             divz,
    output logic [WIDTH-1:0] zhi,
    output logic [WIDTH-1:0] zlo
);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [4:0]         count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               divz_q, divz_d;
    logic [WIDTH-1:0]   zhi_q, zhi_d;
    logic [WIDTH-1:0]   zlo_q, zlo_d;

    logic [2*WIDTH-1:0] booth_acc_s;
    logic               booth_qm1_s;

`ifdef MULDIV_DIV_EN
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH:0]     div_trial_s;

    // acc holds {rem, quo}; trial-subtract the divisor from the remainder after the left shift.
    assign div_trial_s = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
`endif

    booth_step u_booth_step (
        .acc_i (acc_q),
        .qm1_i (qm1_q),
        .a_i   (opnd_q),
        .acc_o (booth_acc_s),
        .qm1_o (booth_qm1_s)
    );

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        qm1_d   = qm1_q;
        opnd_d  = opnd_q;
        count_d = count_q;
        divz_d  = divz_q;
        zhi_d   = zhi_q;
        zlo_d   = zlo_q;
`ifdef MULDIV_DIV_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    divz_d  = 1'b0;
                    count_d = 5'd0;
                    if (op == OP_MUL) begin
                        acc_d   = {{WIDTH{1'b0}}, b};
                        opnd_d  = a;
                        qm1_d   = 1'b0;
                        state_d = MUL;
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (b == 32'd0) begin
                            zlo_d   = 32'hFFFF_FFFF;
                            zhi_d   = a;
                            divz_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, abs_val(a)};
                            opnd_d  = abs_val(b);
                            qneg_d  = a[WIDTH-1] ^ b[WIDTH-1];
                            rneg_d  = a[WIDTH-1];
                            state_d = DIV;
                        end
`else
                        zhi_d   = 32'd0;
                        zlo_d   = 32'd0;
                        divz_d  = 1'b1;
                        state_d = DONE;
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                acc_d   = booth_acc_s;
                qm1_d   = booth_qm1_s;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    zhi_d   = booth_acc_s[2*WIDTH-1:WIDTH];
                    zlo_d   = booth_acc_s[WIDTH-1:0];
                    count_d = 5'd0;
                    state_d = DONE;
                end else begin
                    state_d = MUL;
                end
            end
`ifdef MULDIV_DIV_EN
            DIV: begin
                if (!div_trial_s[WIDTH]) begin
                    acc_d = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    count_d = 5'd0;
                    state_d = FIX;
                end else begin
                    state_d = DIV;
                end
            end
            FIX: begin
                zlo_d   = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                zhi_d   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                state_d = DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == MUL) || (state_d == DIV) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            acc_q   <= {(2*WIDTH){1'b0}};
            qm1_q   <= 1'b0;
            opnd_q  <= 32'd0;
            count_q <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
            zhi_q   <= 32'd0;
            zlo_q   <= 32'd0;
`ifdef MULDIV_DIV_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            qm1_q   <= qm1_d;
            opnd_q  <= opnd_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            divz_q  <= divz_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
`ifdef MULDIV_DIV_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign divz = divz_q;
    assign zhi  = zhi_q;
    assign zlo  = zlo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, handshake corner
// sequences and randomized operations against an arithmetic reference model.
module tb_mul_div_unit;

    logic        clk;
    logic        clr;
    logic        start;
    logic        op_in;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        divz;
    logic [31:0] zhi;
    logic [31:0] zlo;

    int n_total;
    int n_pass;

    mul_div_unit dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .op    (op_in),
        .a     (a_in),
        .b     (b_in),
        .busy  (busy),
        .done  (done),
        .divz  (divz),
        .zhi   (zhi),
        .zlo   (zlo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    task automatic model(input logic op_v, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output logic dz, output int lat);
        longint p;
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (op_v == 1'b0) begin
            p   = sa * sb;
            hi  = p[63:32];
            lo  = p[31:0];
            dz  = 1'b0;
            lat = 33;
        end else begin
`ifdef MULDIV_DIV_EN
            if (bv == 32'd0) begin
                hi  = av;
                lo  = 32'hFFFF_FFFF;
                dz  = 1'b1;
                lat = 1;
            end else begin
                q   = sa / sb;
                r   = sa % sb;
                hi  = r[31:0];
                lo  = q[31:0];
                dz  = 1'b0;
                lat = 34;
            end
`else
            hi  = 32'd0;
            lo  = 32'd0;
            dz  = 1'b1;
            lat = 1;
`endif
        end
    endtask

    // Issue one operation, then scramble the inputs to prove they were latched.
    task automatic run_op(input logic op_v, input logic [31:0] av, input logic [31:0] bv,
                          output int dcyc, output int bcnt,
                          output logic [31:0] rhi, output logic [31:0] rlo,
                          output logic rdz, output logic one_shot);
        dcyc = -1;
        bcnt = 0;
        rhi  = 32'd0;
        rlo  = 32'd0;
        rdz  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        op_in = op_v;
        a_in  = av;
        b_in  = bv;
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                op_in = ~op_v;
                a_in  = $urandom;
                b_in  = $urandom;
            end
            if (busy) bcnt++;
            if (done) begin
                dcyc = c;
                rhi  = zhi;
                rlo  = zlo;
                rdz  = divz;
                break;
            end
        end
        @(negedge clk);
        one_shot = !done;
    endtask

    task automatic verify(input string nm, input logic op_v, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic edz, input int elat);
        int          dcyc;
        int          bcnt;
        logic [31:0] rhi;
        logic [31:0] rlo;
        logic        rdz;
        logic        one;
        run_op(op_v, av, bv, dcyc, bcnt, rhi, rlo, rdz, one);
        chk({nm, " done_cycle"}, 64'(dcyc), 64'(elat));
        chk({nm, " busy_cycles"}, 64'(bcnt), 64'(elat - 1));
        chk({nm, " zhi"}, {32'd0, rhi}, {32'd0, ehi});
        chk({nm, " zlo"}, {32'd0, rlo}, {32'd0, elo});
        chk({nm, " divz"}, {63'd0, rdz}, {63'd0, edz});
        chk({nm, " done_one_cycle"}, {63'd0, one}, 64'd1);
    endtask

    vec_t        vecs[10];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_dz;
    int          m_lat;
    int          n_done;
    int          first_done;
    int          second_done;

    initial begin
        n_total = 0;
        n_pass  = 0;
        clr     = 1'b1;
        start   = 1'b0;
        op_in   = 1'b0;
        a_in    = 32'd0;
        b_in    = 32'd0;

        vecs[0] = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
        vecs[1] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33};
        vecs[3] = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33};
        vecs[4] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, 33};
        vecs[5] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[6] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
        vecs[7] = '{1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[8] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[9] = '{1'b1, 32'h0000_0003, 32'h0000_0007, 32'h0000_0003, 32'h0000_0000, 1'b0, 34};
`ifndef MULDIV_DIV_EN
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].op == 1'b1) begin
                vecs[i].exp_hi  = 32'd0;
                vecs[i].exp_lo  = 32'd0;
                vecs[i].exp_dz  = 1'b1;
                vecs[i].exp_lat = 1;
            end
        end
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset divz", {63'd0, divz}, 64'd0);
        chk("reset zhi_zlo", {zhi, zlo}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            verify($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz, vecs[i].exp_lat);
        end

        // Results hold while idle.
        repeat (5) @(negedge clk);
        chk("hold zhi_zlo", {zhi, zlo}, {vecs[9].exp_hi, vecs[9].exp_lo});

        // clr in cycle 10 of a MUL aborts it without a done pulse.
        @(negedge clk);
        start = 1'b1;
        op_in = 1'b0;
        a_in  = 32'h0001_0001;
        b_in  = 32'h0000_0100;
        @(posedge clk);
        n_done = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) n_done++;
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr busy", {63'd0, busy}, 64'd0);
        chk("clr zhi_zlo", {zhi, zlo}, 64'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("clr no_done", 64'(n_done), 64'd0);
        verify("after_clr 3x4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33);

        // start pulses during a running MUL are not queued.
        @(negedge clk);
        start = 1'b1;
        op_in = 1'b0;
        a_in  = 32'd9;
        b_in  = 32'd11;
        @(posedge clk);
        n_done     = 0;
        first_done = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            start = (c == 5) || (c == 20);
        end
        chk("ignored_start done_count", 64'(n_done), 64'd1);
        chk("ignored_start done_cycle", 64'(first_done), 64'd33);
        chk("ignored_start zlo", {32'd0, zlo}, 64'd99);

        // start held high: back-to-back MULs every 34 cycles.
        @(negedge clk);
        start = 1'b1;
        op_in = 1'b0;
        a_in  = 32'd2;
        b_in  = 32'd5;
        @(posedge clk);
        first_done  = -1;
        second_done = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (done) begin
                if (first_done < 0) first_done = c;
                else second_done = c;
            end
            if (second_done > 0) begin
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        chk("held_start first_done", 64'(first_done), 64'd33);
        chk("held_start second_done", 64'(second_done), 64'd67);
        repeat (40) @(negedge clk);

        // Randomized operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            logic        rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 1'(($urandom) & 32'd1);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = $urandom_range(1, 15);
                default: ;
            endcase
            model(rop, ra, rb, m_hi, m_lo, m_dz, m_lat);
            verify($sformatf("rand%0d op=%0d a=%h b=%h", i, rop, ra, rb),
                   rop, ra, rb, m_hi, m_lo, m_dz, m_lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
